// File: rtl/alu0_issue_queue_if.sv
// Dispatch, wakeup and select bundle of the ALU0 issue queue.
// slave: the issue queue; master: the dispatch/wakeup/register-read side driving it.
interface alu0_issue_queue_if #(
    parameter int unsigned PR_W  = 6,
    parameter int unsigned ROB_W = 6
);
    // Dispatch request and payload
    logic             disp_vld;
    logic             disp_rdy;
    logic [4:0]       disp_op;
    logic [19:0]      disp_imm;
    logic [PR_W-1:0]  disp_dest;
    logic [PR_W-1:0]  disp_src1;
    logic             disp_src1_rdy;
    logic [PR_W-1:0]  disp_src2;
    logic             disp_src2_rdy;
    logic [ROB_W-1:0] disp_ROB_ID;

    // External wakeup broadcasts
    logic             wake0_vld;
    logic [PR_W-1:0]  wake0_PR;
    logic             wake1_vld;
    logic [PR_W-1:0]  wake1_PR;

    // Registered select bundle towards ALU0 register read
    logic             ALU0_select_vld;
    logic [4:0]       ALU0_select_op;
    logic [19:0]      ALU0_select_imm;
    logic [PR_W-1:0]  ALU0_select_dest;
    logic [PR_W-1:0]  ALU0_select_source1;
    logic [PR_W-1:0]  ALU0_select_source2;
    logic [ROB_W-1:0] ALU0_select_ROB_ID;

    modport master (
        output disp_vld, disp_op, disp_imm, disp_dest, disp_src1, disp_src1_rdy,
               disp_src2, disp_src2_rdy, disp_ROB_ID,
               wake0_vld, wake0_PR, wake1_vld, wake1_PR,
        input  disp_rdy,
               ALU0_select_vld, ALU0_select_op, ALU0_select_imm, ALU0_select_dest,
               ALU0_select_source1, ALU0_select_source2, ALU0_select_ROB_ID
    );

    modport slave (
        input  disp_vld, disp_op, disp_imm, disp_dest, disp_src1, disp_src1_rdy,
               disp_src2, disp_src2_rdy, disp_ROB_ID,
               wake0_vld, wake0_PR, wake1_vld, wake1_PR,
        output disp_rdy,
               ALU0_select_vld, ALU0_select_op, ALU0_select_imm, ALU0_select_dest,
               ALU0_select_source1, ALU0_select_source2, ALU0_select_ROB_ID
    );
endinterface

// File: rtl/alu0_issue_queue.sv
// ALU0 out-of-order issue queue: compacting age-ordered storage (entry 0 oldest),
// wakeup tracking including self-wakeup, oldest-ready select and registered issue bundle.
module alu0_issue_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PR_W  = 6,
    parameter int unsigned ROB_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    alu0_issue_queue_if.slave     bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    // Entry storage
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] src1_rdy_q, src1_rdy_d;
    logic [DEPTH-1:0] src2_rdy_q, src2_rdy_d;
    logic [4:0]       op_q   [DEPTH];
    logic [4:0]       op_d   [DEPTH];
    logic [19:0]      imm_q  [DEPTH];
    logic [19:0]      imm_d  [DEPTH];
    logic [PR_W-1:0]  dest_q [DEPTH];
    logic [PR_W-1:0]  dest_d [DEPTH];
    logic [PR_W-1:0]  src1_q [DEPTH];
    logic [PR_W-1:0]  src1_d [DEPTH];
    logic [PR_W-1:0]  src2_q [DEPTH];
    logic [PR_W-1:0]  src2_d [DEPTH];
    logic [ROB_W-1:0] rob_q  [DEPTH];
    logic [ROB_W-1:0] rob_d  [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;

    // Issue register
    logic             sel_vld_q;
    logic [4:0]       sel_op_q;
    logic [19:0]      sel_imm_q;
    logic [PR_W-1:0]  sel_dest_q;
    logic [PR_W-1:0]  sel_src1_q;
    logic [PR_W-1:0]  sel_src2_q;
    logic [ROB_W-1:0] sel_rob_q;

    logic             found;
    logic [IDX_W-1:0] sel_idx;
    logic [PR_W-1:0]  self_tag;
    logic             disp_fire;
    logic [CNT_W-1:0] wr_cnt;

    // True when tag matches any of the three wakeups broadcast this cycle
    function automatic logic woke(
        input logic [PR_W-1:0] tag,
        input logic            v0,
        input logic [PR_W-1:0] t0,
        input logic            v1,
        input logic [PR_W-1:0] t1,
        input logic            vs,
        input logic [PR_W-1:0] ts
    );
        return (v0 && (tag == t0)) || (v1 && (tag == t1)) || (vs && (tag == ts));
    endfunction

    assign bus.disp_rdy = (count_q != CNT_W'(DEPTH));
    assign disp_fire    = bus.disp_vld && bus.disp_rdy;
    // An issue this cycle frees one slot below the tail before the new op lands
    assign wr_cnt       = count_q - CNT_W'(found);
    assign self_tag     = dest_q[sel_idx];

    // Select the lowest-index (oldest) entry with both operands ready
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (valid_q[i] && src1_rdy_q[i] && src2_rdy_q[i]) begin
                found   = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end

    // Next entry state: wakeup, compaction above the issued slot, dispatch write, flush
    always_comb begin
        valid_d    = '0;
        src1_rdy_d = '0;
        src2_rdy_d = '0;
        count_d    = count_q + CNT_W'(disp_fire) - CNT_W'(found);
        for (int i = 0; i < int'(DEPTH); i++) begin
            logic             shift;
            logic [IDX_W-1:0] src;
            shift = found && (IDX_W'(i) >= sel_idx);
            src   = shift ? IDX_W'((i + 1) % int'(DEPTH)) : IDX_W'(i);

            // The top slot has nothing above it to pull down when shifting
            valid_d[i]    = (shift && (i == int'(DEPTH) - 1)) ? 1'b0 : valid_q[src];
            src1_rdy_d[i] = src1_rdy_q[src] || woke(src1_q[src], bus.wake0_vld, bus.wake0_PR,
                                                    bus.wake1_vld, bus.wake1_PR, found, self_tag);
            src2_rdy_d[i] = src2_rdy_q[src] || woke(src2_q[src], bus.wake0_vld, bus.wake0_PR,
                                                    bus.wake1_vld, bus.wake1_PR, found, self_tag);
            op_d[i]   = op_q[src];
            imm_d[i]  = imm_q[src];
            dest_d[i] = dest_q[src];
            src1_d[i] = src1_q[src];
            src2_d[i] = src2_q[src];
            rob_d[i]  = rob_q[src];

            if (disp_fire && (CNT_W'(i) == wr_cnt)) begin
                valid_d[i]    = 1'b1;
                src1_rdy_d[i] = bus.disp_src1_rdy ||
                                woke(bus.disp_src1, bus.wake0_vld, bus.wake0_PR,
                                     bus.wake1_vld, bus.wake1_PR, found, self_tag);
                src2_rdy_d[i] = bus.disp_src2_rdy ||
                                woke(bus.disp_src2, bus.wake0_vld, bus.wake0_PR,
                                     bus.wake1_vld, bus.wake1_PR, found, self_tag);
                op_d[i]   = bus.disp_op;
                imm_d[i]  = bus.disp_imm;
                dest_d[i] = bus.disp_dest;
                src1_d[i] = bus.disp_src1;
                src2_d[i] = bus.disp_src2;
                rob_d[i]  = bus.disp_ROB_ID;
            end
        end
        if (flush) begin
            valid_d = '0;
            count_d = '0;
        end
    end

    // Entry storage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            src1_rdy_q <= '0;
            src2_rdy_q <= '0;
            count_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                op_q[i]   <= '0;
                imm_q[i]  <= '0;
                dest_q[i] <= '0;
                src1_q[i] <= '0;
                src2_q[i] <= '0;
                rob_q[i]  <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            src1_rdy_q <= src1_rdy_d;
            src2_rdy_q <= src2_rdy_d;
            count_q    <= count_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                op_q[i]   <= op_d[i];
                imm_q[i]  <= imm_d[i];
                dest_q[i] <= dest_d[i];
                src1_q[i] <= src1_d[i];
                src2_q[i] <= src2_d[i];
                rob_q[i]  <= rob_d[i];
            end
        end
    end

    // Issue register: valid is killed by flush, payload only reloads on a select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_vld_q  <= 1'b0;
            sel_op_q   <= '0;
            sel_imm_q  <= '0;
            sel_dest_q <= '0;
            sel_src1_q <= '0;
            sel_src2_q <= '0;
            sel_rob_q  <= '0;
        end else begin
            sel_vld_q <= found && !flush;
            if (found) begin
                sel_op_q   <= op_q[sel_idx];
                sel_imm_q  <= imm_q[sel_idx];
                sel_dest_q <= dest_q[sel_idx];
                sel_src1_q <= src1_q[sel_idx];
                sel_src2_q <= src2_q[sel_idx];
                sel_rob_q  <= rob_q[sel_idx];
            end
        end
    end

    assign bus.ALU0_select_vld     = sel_vld_q;
    assign bus.ALU0_select_op      = sel_op_q;
    assign bus.ALU0_select_imm     = sel_imm_q;
    assign bus.ALU0_select_dest    = sel_dest_q;
    assign bus.ALU0_select_source1 = sel_src1_q;
    assign bus.ALU0_select_source2 = sel_src2_q;
    assign bus.ALU0_select_ROB_ID  = sel_rob_q;
endmodule
